// File: rtl/disp_samples_multi.sv
// disp_samples_multi: captures SIZE samples on each of CH channels into an
// internal buffer, then plots every enabled channel into a W x H RGB565
// frame buffer as dots (one pixel per sample) or as connected line segments.
//
// Ports
//   clkSYS      system clock, all state on the rising edge
//   reset       synchronous active-high reset
//   start       frame request pulse (honoured only while idle)
//   done        one-cycle frame-complete pulse
//   stat        buffer select latched at start: 1 = SWAP, 0 = BASE
//   ch_en       per-channel enable, latched at start
//   mode        0 = dots, 1 = vectors, latched at start
//   arb_*       pixel write port: req/ack handshake, addr, data, wr (always 1)
//   smpl_*      sample source: req/valid handshake, CH packed samples
//
// draw_line: Bresenham line stepper. Presents (x0,y0) after start and moves
// one pixel toward (x1,y1) per step; last flags the endpoint pixel.

module draw_line #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             step,
  output logic             valid,
  output logic             last,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  localparam int unsigned EW = WIDTH + 3;

  logic [WIDTH-1:0]        x_q, y_q, xe_q, ye_q, x_d, y_d, adx, ady;
  logic signed [EW-1:0]    dx_q, dy_q, err_q, err_d, e2;
  logic                    sx_q, sy_q, busy_q;

  always_comb begin
    adx   = (x1 >= x0) ? x1 - x0 : x0 - x1;
    ady   = (y1 >= y0) ? y1 - y0 : y0 - y1;
    e2    = err_q <<< 1;
    err_d = err_q;
    x_d   = x_q;
    y_d   = y_q;
    // Both tests use the error before this step, so diagonal moves are possible.
    if (e2 >= dy_q) begin
      err_d = err_d + dy_q;
      x_d   = sx_q ? x_q - WIDTH'(1) : x_q + WIDTH'(1);
    end
    if (e2 <= dx_q) begin
      err_d = err_d + dx_q;
      y_d   = sy_q ? y_q - WIDTH'(1) : y_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      x_q    <= x0;
      y_q    <= y0;
      xe_q   <= x1;
      ye_q   <= y1;
      sx_q   <= (x1 < x0);
      sy_q   <= (y1 < y0);
      dx_q   <= $signed({3'b000, adx});
      dy_q   <= -$signed({3'b000, ady});
      err_q  <= $signed({3'b000, adx}) - $signed({3'b000, ady});
    end else if (step && busy_q) begin
      if (last) begin
        busy_q <= 1'b0;
      end else begin
        x_q   <= x_d;
        y_q   <= y_d;
        err_q <= err_d;
      end
    end
  end

  assign valid = busy_q;
  assign last  = (x_q == xe_q) && (y_q == ye_q);
  assign x     = x_q;
  assign y     = y_q;
endmodule

module disp_samples_multi #(
  parameter int unsigned CH      = 2,
  parameter int unsigned SW      = 12,
  parameter int unsigned SIZE    = 256,
  parameter int unsigned W       = 320,
  parameter int unsigned H       = 240,
  parameter logic [31:0] BASE    = '0,
  parameter logic [31:0] SWAP    = '0,
  parameter logic [63:0] COLOURS = {16'hf800, 16'h07e0, 16'h001f, 16'hffe0}
) (
  input  logic             clkSYS,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  input  logic             stat,
  input  logic [CH-1:0]    ch_en,
  input  logic             mode,
  output logic             arb_req,
  input  logic             arb_ack,
  output logic [31:0]      arb_addr,
  output logic [15:0]      arb_data,
  output logic             arb_wr,
  input  logic             smpl_valid,
  output logic             smpl_req,
  input  logic [CH*SW-1:0] smpl
);
  localparam int unsigned CW    = 10;
  localparam int unsigned CNTW  = $clog2(SIZE + 1);
  localparam int unsigned KW    = $clog2(SIZE);
  localparam int unsigned CHW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned XSTEP = (W - 1) / (SIZE - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, LOAD, DRAW, NEXT} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d, idx0;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CH-1:0]   en_q, en_d;
  logic            stat_q, stat_d, mode_q, mode_d, done_q, done_d;
  logic [CHW:0]    found;
  logic [SW-1:0]   buf_q [CH][SIZE];

  logic            line_start, line_valid, line_last, pix_ack;
  logic [CW-1:0]   lx0, ly0, lx1, ly1, px, py;

  // {hit, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [CHW:0] find_ch(input logic [CH-1:0] en, input int unsigned from);
    logic [CHW:0] r;
    r = '0;
    for (int unsigned c = CH; c > 0; c--) begin
      if ((c - 1 >= from) && en[c-1]) r = {1'b1, CHW'(c - 1)};
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] pt_x(input logic [KW-1:0] i);
    return CW'(32'(i) * XSTEP);
  endfunction

  // Product kept at 32 bits so the shift sees every bit of s*H.
  function automatic logic [CW-1:0] pt_y(input logic [SW-1:0] s);
    logic [31:0] t;
    t = (32'(s) * H) >> SW;
    return CW'(H - 1 - t);
  endfunction

  // Dots are zero-length segments (i,i); vectors join samples (i-1,i).
  assign idx0 = k_q - KW'(mode_q);
  assign lx0  = pt_x(idx0);
  assign ly0  = pt_y(buf_q[ch_q][idx0]);
  assign lx1  = pt_x(k_q);
  assign ly1  = pt_y(buf_q[ch_q][k_q]);

  assign line_start = (state_q == LOAD);
  assign arb_req    = (state_q == DRAW) && line_valid;
  assign pix_ack    = arb_req && arb_ack;
  assign arb_addr   = (stat_q ? SWAP : BASE) | (32'(py) * W + 32'(px));
  assign arb_data   = COLOURS[16*ch_q +: 16];
  assign arb_wr     = 1'b1;
  assign smpl_req   = (state_q == CAPTURE) && (cnt_q < CNTW'(SIZE));
  assign done       = done_q;

  draw_line #(.WIDTH(CW)) u_line (
    .clk   (clkSYS),
    .reset (reset),
    .start (line_start),
    .x0    (lx0),
    .y0    (ly0),
    .x1    (lx1),
    .y1    (ly1),
    .step  (pix_ack),
    .valid (line_valid),
    .last  (line_last),
    .x     (px),
    .y     (py)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    ch_d    = ch_q;
    en_d    = en_q;
    stat_d  = stat_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    found   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stat_d  = stat;
          en_d    = ch_en;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (smpl_req && smpl_valid) begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(SIZE - 1)) begin
            found = find_ch(en_q, 0);
            if (found[CHW]) begin
              ch_d    = found[CHW-1:0];
              k_d     = KW'(mode_q);
              state_d = LOAD;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      LOAD: state_d = DRAW;
      DRAW: begin
        if (pix_ack && line_last) begin
          if (k_q == KW'(SIZE - 1)) begin
            state_d = NEXT;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = LOAD;
          end
        end
      end
      NEXT: begin
        found = find_ch(en_q, 32'(ch_q) + 1);
        if (found[CHW]) begin
          ch_d    = found[CHW-1:0];
          k_d     = KW'(mode_q);
          state_d = LOAD;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      ch_q    <= '0;
      en_q    <= '0;
      stat_q  <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clkSYS) begin
    if (!reset && smpl_req && smpl_valid) begin
      for (int unsigned c = 0; c < CH; c++) begin
        buf_q[c[CHW-1:0]][cnt_q[KW-1:0]] <= smpl[SW*c +: SW];
      end
    end
  end
endmodule

// File: tb/tb_disp_samples_multi.sv
// Directed bench for disp_samples_multi with CH=2, SW=12, SIZE=4, W=16, H=8,
// BASE=0, SWAP=1024; channel 0 colour f800, channel 1 colour 07e0.
module tb_disp_samples_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stat, mode, arb_ack, alt;
  logic        smpl_valid = 1'b1;
  logic [1:0]  ch_en;
  logic        done, arb_req, arb_wr, smpl_req;
  logic [31:0] arb_addr;
  logic [15:0] arb_data;
  logic [23:0] smpl;
  logic [11:0] s0 [4];
  logic [11:0] s1 [4];
  logic [1:0]  bidx;

  int total = 0;
  int bad = 0;
  int beats = 0;
  int beat_base = 0;
  int done_cnt = 0;
  int req_cycles = 0;
  logic [31:0] wa[$];
  logic [15:0] wd[$];

  int unsigned vec_exp [24] = '{112, 97, 81, 66, 51, 36, 20, 5,
                                5, 22, 38, 55, 72, 89, 105, 122,
                                122, 107, 91, 76, 61, 46, 30, 15};

  disp_samples_multi #(
    .CH(2), .SW(12), .SIZE(4), .W(16), .H(8),
    .BASE(32'd0), .SWAP(32'd1024),
    .COLOURS({16'hffe0, 16'h001f, 16'h07e0, 16'hf800})
  ) dut (
    .clkSYS(clk), .reset(reset), .start(start), .done(done), .stat(stat),
    .ch_en(ch_en), .mode(mode), .arb_req(arb_req), .arb_ack(arb_ack),
    .arb_addr(arb_addr), .arb_data(arb_data), .arb_wr(arb_wr),
    .smpl_valid(smpl_valid), .smpl_req(smpl_req), .smpl(smpl)
  );

  assign bidx = 2'(beats - beat_base);
  assign smpl = {s1[bidx], s0[bidx]};

  always @(posedge clk) if (smpl_req && smpl_valid) beats <= beats + 1;

  always @(posedge clk) begin
    #1;
    smpl_valid = alt ? ~smpl_valid : 1'b1;
  end

  always @(negedge clk) begin
    if (arb_req) req_cycles++;
    if (arb_req && arb_ack) begin
      wa.push_back(arb_addr);
      wd.push_back(arb_data);
    end
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] en, input logic st, input logic md);
    @(posedge clk); #1;
    beat_base = beats;
    ch_en = en; stat = st; mode = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ch_en = ~en; stat = ~st; mode = ~md;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int n = 0; n < 400 && done_cnt == d0; n++) @(posedge clk);
    check_eq({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_dots(input string tag, input int wb, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3, input logic [15:0] ed);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    check_eq({tag, "_count"}, 32'(wa.size() - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wa.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), wa[wb+i], e[i]);
        check_eq($sformatf("%s_data%0d", tag, i), 32'(wd[wb+i]), 32'(ed));
      end
    end
  endtask

  initial begin
    int wb, db, rb;
    reset = 1'b1; start = 1'b0; stat = 1'b0; mode = 1'b0; ch_en = 2'b00;
    arb_ack = 1'b1; alt = 1'b0;
    for (int i = 0; i < 4; i++) begin s0[i] = '0; s1[i] = 12'd2048; end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arb_req", 32'(arb_req), 32'd0);
    check_eq("rst_smpl_req", 32'(smpl_req), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wr", 32'(arb_wr), 32'd1);
    reset = 1'b0;

    // dots, channel 0, all-zero samples -> bottom row
    wb = wa.size(); db = done_cnt;
    pulse_start(2'b01, 1'b0, 1'b0);
    wait_done("dots0", db);
    check_dots("dots0", wb, 32'd112, 32'd117, 32'd122, 32'd127, 16'hf800);
    check_eq("dots0_done_once", 32'(done_cnt - db), 32'd1);

    // dots, channel 1, full-scale samples, SWAP buffer, gappy valid
    for (int i = 0; i < 4; i++) s1[i] = 12'd4095;
    alt = 1'b1;
    wb = wa.size(); db = done_cnt;
    pulse_start(2'b10, 1'b1, 1'b0);
    wait_done("dots1", db);
    alt = 1'b0;
    check_dots("dots1", wb, 32'd1024, 32'd1029, 32'd1034, 32'd1039, 16'h07e0);

    // vectors, channel 0, zig-zag
    s0[0] = 12'd0; s0[1] = 12'd4095; s0[2] = 12'd0; s0[3] = 12'd4095;
    wb = wa.size(); db = done_cnt;
    pulse_start(2'b01, 1'b0, 1'b1);
    wait_done("vec", db);
    check_eq("vec_count", 32'(wa.size() - wb), 32'd24);
    for (int i = 0; i < 24; i++) begin
      if (wb + i < wa.size()) begin
        check_eq($sformatf("vec_addr%0d", i), wa[wb+i], vec_exp[i]);
        check_eq($sformatf("vec_data%0d", i), 32'(wd[wb+i]), 32'hf800);
      end
    end

    // no channels enabled
    rb = req_cycles; db = done_cnt;
    pulse_start(2'b00, 1'b0, 1'b0);
    wait_done("none", db);
    check_eq("none_beats", 32'(beats - beat_base), 32'd4);
    check_eq("none_req", 32'(req_cycles - rb), 32'd0);
    check_eq("none_done_once", 32'(done_cnt - db), 32'd1);

    // ack withheld, start pulsed mid-frame
    for (int i = 0; i < 4; i++) s0[i] = '0;
    arb_ack = 1'b0;
    wb = wa.size(); db = done_cnt;
    pulse_start(2'b01, 1'b0, 1'b0);
    for (int n = 0; n < 50 && !arb_req; n++) begin @(posedge clk); #1; end
    check_eq("hold_req_up", 32'(arb_req), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = (k == 1);
      check_eq($sformatf("hold_req%0d", k), 32'(arb_req), 32'd1);
      check_eq($sformatf("hold_addr%0d", k), arb_addr, 32'd112);
      check_eq($sformatf("hold_data%0d", k), 32'(arb_data), 32'hf800);
    end
    start = 1'b0;
    arb_ack = 1'b1;
    wait_done("hold", db);
    repeat (10) @(posedge clk);
    #1;
    check_dots("hold", wb, 32'd112, 32'd117, 32'd122, 32'd127, 16'hf800);
    check_eq("hold_done_once", 32'(done_cnt - db), 32'd1);
    check_eq("hold_beats", 32'(beats - beat_base), 32'd4);

    // reset during Draw
    arb_ack = 1'b0;
    wb = wa.size(); db = done_cnt;
    pulse_start(2'b01, 1'b0, 1'b0);
    for (int n = 0; n < 50 && !arb_req; n++) begin @(posedge clk); #1; end
    check_eq("rstd_req_up", 32'(arb_req), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rstd_arb_req", 32'(arb_req), 32'd0);
    check_eq("rstd_smpl_req", 32'(smpl_req), 32'd0);
    arb_ack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("rstd_no_done", 32'(done_cnt - db), 32'd0);
    check_eq("rstd_no_write", 32'(wa.size() - wb), 32'd0);
    wb = wa.size(); db = done_cnt;
    pulse_start(2'b01, 1'b0, 1'b0);
    wait_done("rerun", db);
    check_dots("rerun", wb, 32'd112, 32'd117, 32'd122, 32'd127, 16'hf800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
